siso_shift_reg: RTL
===================

Name: siso_shift_reg

Overview:
- Parameterised serial-in/serial-out delay line built on single-bit flop storage.
- Feeds the flop stage downstream and sits between a serial bit source and the bit consumer.
- Each accepted bit emerges exactly DEPTH accepted bits later.
- A flush sequence pads with FILL_BIT and drains all stored real bits without new input.
- Valid/ready handshakes on both sides.

Parameters:
- DEPTH, 4: number of bit stages; legal range 2..64.
- FILL_BIT, 1'b0: value shifted in during pad and flush.
- CW, $clog2(DEPTH+1): width of the level counter; derived, do not override.

Ports:
- Interface: one clock; reset is synchronous and active-high.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_data  in  1  serial input bit.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  1  oldest stored bit, sr[DEPTH-1].
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer takes out_data this cycle.
- flush  in  1  request to drain stored bits; sampled when the block is not busy.
- busy  out  1  high in PAD or FLUSH.
- flush_done  out  1  one-cycle pulse on the final drained bit.
- level  out  CW  count of real bits stored.

Behaviour:
- Storage sr[DEPTH-1:0]. A shift does sr <= {sr[DEPTH-2:0], bit_in}.
- Firing: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset: sr = 0, level = 0, state = FILL, in_ready = 1, out_valid = 0, busy = 0, flush_done = 0.
- FILL state (level < DEPTH):
  - in_ready = 1, out_valid = 0.
  - in_fire shifts in_data and increments level.
  - When level reaches DEPTH, go to RUN.
- RUN state (level == DEPTH):
  - in_ready = out_ready; out_valid = in_valid (combinational pass-through, documented).
  - A shift happens only when both sides fire in the same cycle; level stays DEPTH.
  - No output leaves without a paired input.
- flush in FILL with level == 0: ignored; no flush_done.
- flush in FILL with level > 0: go to PAD.
- flush in RUN: go to FLUSH with remaining = DEPTH.
- flush in the same cycle as in_fire: the input bit is taken first, then the state moves. The level used is the post-accept value.
- PAD state:
  - in_ready = 0, out_valid = 0.
  - Shift FILL_BIT every cycle, unconditionally, DEPTH - level times.
  - After padding, the oldest real bit is at sr[DEPTH-1]. Go to FLUSH with remaining = level.
- FLUSH state:
  - in_ready = 0, out_valid = 1.
  - Each out_fire shifts FILL_BIT and decrements remaining and level.
  - Hold while out_ready = 0.
  - On the out_fire with remaining == 1: assert flush_done for that cycle, then return to FILL with level = 0.
- flush while busy: ignored.
- rst mid-PAD or mid-FLUSH: immediate return to reset values; no flush_done.
- level never exceeds DEPTH and never underflows.
- busy = (state == PAD) | (state == FLUSH).
- Latency: a bit accepted at in_fire number k is presented at out_data on in_fire number k+DEPTH, or during the drain.

Decomposition:
- Shared package siso_pkg:
  - state enum {FILL, RUN, PAD, FLUSH}, 2-bit encoding.
  - Constants DEPTH_MIN = 2 and DEPTH_MAX = 64.
- One natural sub-module, siso_stage: a single flop with shift enable and sync reset, instantiated DEPTH times in a generate loop.
- Control FSM and counters stay in the top module.

Test Plan (DEPTH = 4, FILL_BIT = 0):
- Reset then fill: rst 2 cycles, then in 1,0,1,1 with out_ready = 1 -> out_valid = 0 throughout; level = 1,2,3,4; state RUN after the 4th bit.
- Streaming: after fill, feed 0,0,1,0 with out_ready = 1 -> out_data sequence 1,0,1,1 on the paired fires; level stays 4.
- Backpressure in RUN: in_valid = 1, out_ready = 0 for 3 cycles -> in_ready = 0, sr and level unchanged; resumes correctly when out_ready rises.
- Partial flush: feed 1,1 then pulse flush -> busy = 1; 2 PAD cycles with no output; FLUSH emits 1,1; flush_done pulses on the 2nd bit; then level = 0 and in_ready = 1.
- Full flush with stalls: in RUN holding 1,0,0,1, flush while out_ready toggles 1,0,1,1,0,1 -> drains 1,0,0,1 only on fire cycles, flush_done on the last.
- Reset mid-FLUSH: rst asserted after 1 drained bit -> next cycle out_valid = 0, busy = 0, level = 0; flush_done never pulses.

Source files
------------

// File: rtl/siso_shift_reg_pkg.sv
`default_nettype none
// ============================================================================
// siso_pkg : shared types and limits for the siso_shift_reg delay line
// Rev 1.0
// ============================================================================
package siso_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    PAD   = 2'd2,
    FLUSH = 2'd3
  } state_e;

  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 64;

endpackage
`default_nettype wire

// File: rtl/siso_shift_reg_if.sv
`default_nettype none
// ============================================================================
// siso_shift_reg_if : serial input/output handshake bundle
// Rev 1.0
// ============================================================================
interface siso_shift_reg_if;
  logic in_data;
  logic in_valid;
  logic in_ready;
  logic out_data;
  logic out_valid;
  logic out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/siso_shift_reg_stage.sv
`default_nettype none
// ============================================================================
// siso_stage : one storage bit with shift enable and synchronous reset
// Rev 1.0
// ============================================================================
module siso_stage (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic en,
  input  wire logic d,
  output logic      q
);
  logic data_q;
  logic data_d;

  always_comb begin
    data_d = data_q;
    if (en) data_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= 1'b0;
    else     data_q <= data_d;
  end

  assign q = data_q;
endmodule
`default_nettype wire

// File: rtl/siso_shift_reg.sv
`default_nettype none
// ============================================================================
// siso_shift_reg : DEPTH-bit serial delay line with valid/ready and flush drain
// Rev 1.0
// ============================================================================
module siso_shift_reg #(
  parameter int   DEPTH    = 4,
  parameter logic FILL_BIT = 1'b0,
  parameter int   CW       = $clog2(DEPTH + 1)
) (
  input  wire logic          clk,
  input  wire logic          rst,
  siso_shift_reg_if.slave    bus,
  input  wire logic          flush,
  output logic               busy,
  output logic               flush_done,
  output logic [CW-1:0]      level
);
  import siso_pkg::*;

  localparam logic [CW-1:0] DEPTH_L = CW'(DEPTH);

  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("siso_shift_reg: DEPTH out of range");
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   level_q, level_d;
  logic [CW-1:0]   pad_q, pad_d;
  logic [CW-1:0]   lvl_post;
  logic            shift_en;
  logic            bit_in;
  logic            in_ready;
  logic            out_valid;
  logic            done_c;
  logic [DEPTH-1:0] sr;
  logic [DEPTH-1:0] sr_next;

  assign sr_next = {sr[DEPTH-2:0], bit_in};

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    siso_stage u_stage (
      .clk (clk),
      .rst (rst),
      .en  (shift_en),
      .d   (sr_next[i]),
      .q   (sr[i])
    );
  end

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    pad_d     = pad_q;
    lvl_post  = level_q;
    shift_en  = 1'b0;
    bit_in    = FILL_BIT;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    done_c    = 1'b0;

    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          shift_en = 1'b1;
          bit_in   = bus.in_data;
          lvl_post = level_q + CW'(1);
        end
        level_d = lvl_post;
        // Flush decisions use the level after this cycle's accept.
        if (flush && lvl_post != '0) begin
          if (lvl_post == DEPTH_L) begin
            state_d = FLUSH;
          end else begin
            state_d = PAD;
            pad_d   = DEPTH_L - lvl_post;
          end
        end else if (lvl_post == DEPTH_L) begin
          state_d = RUN;
        end
      end
      RUN: begin
        in_ready  = bus.out_ready;
        out_valid = bus.in_valid;
        bit_in    = bus.in_data;
        shift_en  = bus.in_valid & bus.out_ready;
        if (flush) state_d = FLUSH;
      end
      PAD: begin
        shift_en = 1'b1;
        pad_d    = pad_q - CW'(1);
        if (pad_q == CW'(1)) state_d = FLUSH;
      end
      FLUSH: begin
        // Remaining drain count always equals level here.
        out_valid = 1'b1;
        if (bus.out_ready) begin
          shift_en = 1'b1;
          level_d  = level_q - CW'(1);
          if (level_q == CW'(1)) begin
            done_c  = 1'b1;
            state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      level_q <= '0;
      pad_q   <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      pad_q   <= pad_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = sr[DEPTH-1];
  assign busy          = (state_q == PAD) | (state_q == FLUSH);
  assign flush_done    = done_c & ~rst;
  assign level         = level_q;
endmodule
`default_nettype wire
